// File: rtl/blink_stretcher.sv
// blink_stretcher: stretches single-cycle event pulses into fixed-length LED blinks
// separated by a fixed dark gap, queueing events in a saturating counter.
module blink_stretcher #(
   parameter int WIDTH     = 20,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in,
   output logic                 out,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pending
);
   typedef enum logic [1:0] {IDLE = 2'b00, ON = 2'b01, OFF = 2'b10, BAD = 2'b11} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] timer;
   logic timer_done, dec;
   assign timer_done = &timer;
   assign dec        = (state == IDLE) && (pending != '0);
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = dec ? ON : IDLE;
         ON:      state_nxt = timer_done ? OFF : ON;
         OFF:     state_nxt = timer_done ? IDLE : OFF;
         default: state_nxt = IDLE;
      endcase
   end
   // Timer restarts on every transition so each phase lasts exactly 2^WIDTH cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         timer   <= (state_nxt != state || state == IDLE) ? '0 : timer + 1'b1;
         pending <= (in && !dec) ? (&pending ? pending : pending + 1'b1) :
                    (dec && !in) ? pending - 1'b1 : pending;
      end
   end
   assign out  = (state == ON);
   assign busy = (state != IDLE) || (pending != '0);
endmodule

// File: doc/blink_stretcher.md
# blink_stretcher

- Output-side conditioning block. Input debouncing turns a noisy physical level into a clean internal signal; this block does the reverse.
- It turns single-cycle internal event pulses into human-visible LED blinks on a board pin.
- Each event produces exactly one blink of fixed on-time, separated by a fixed dark gap, so back-to-back events stay individually visible.
- Events that arrive while a blink is in progress are queued in a saturating pending counter.

## Interface
- WIDTH, default 20: phase timer width; on-time and gap are each 2^WIDTH cycles.
- CNT_WIDTH, default 4: pending-event counter width; at most 2^CNT_WIDTH-1 queued events.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  event strobe; every cycle sampled high counts as one event.
- out  output  1  LED drive; high only in state ON.
- busy  output  1  high when state is not IDLE or pending is not 0.
- pending  output  CNT_WIDTH  current queued-event count.

## Operation
- State register: 2 bits; IDLE=2'b00, ON=2'b01, OFF=2'b10. Unused code 2'b11 returns to IDLE on the next edge, with out=0.
- Timer: WIDTH bits.
  - Held at 0 in IDLE.
  - Increments every cycle in ON and OFF.
  - Cleared to 0 on every state transition.
- FSM transitions:
  - IDLE: if pending != 0, go to ON and consume one event. Otherwise stay in IDLE. A same-cycle `in` is not looked at directly; it only counts through pending.
  - ON: out=1. When timer == all-ones, go to OFF. Otherwise stay.
  - OFF: out=0. When timer == all-ones, go to IDLE. Otherwise stay.
- Pending counter, with inc = in and dec = (IDLE and pending != 0):
  - inc and not dec: pending+1, saturating at all-ones. Events beyond saturation are dropped silently.
  - dec and not inc: pending-1.
  - Both: unchanged. This applies even at saturation, so the consumed event is replaced.
  - Neither: unchanged.
- Outputs are decoded from registered state and registered pending only; there is no combinational path from `in` to any output.
- Reset:
  - State goes to IDLE, timer to 0, pending to 0.
  - Hence out=0, busy=0, pending=0 in the cycle after reset is sampled.
  - A reset during ON truncates the blink immediately and discards all queued events.
  - `in` sampled in the same cycle as reset is ignored.

## Timing
- Latency: `in` high in cycle t gives pending=1 in cycle t+1. With state IDLE in t+1, state is ON and out=1 in cycle t+2.
- Blink length: out is high for exactly 2^WIDTH consecutive cycles.
- Dark time between consecutive queued blinks is exactly 2^WIDTH+1 cycles: 2^WIDTH in OFF plus one in IDLE.
- Blink period under continuous backlog is 2^(WIDTH+1)+1 cycles.
- busy falls in the first IDLE cycle in which pending == 0.
- An event arriving during ON or OFF is queued. Its blink starts the cycle after the IDLE cycle that follows OFF.

## Test plan
Benches use WIDTH=3 (8-cycle phases) and CNT_WIDTH=2 unless stated. Cycle numbers are relative to the first `in` pulse (cycle 0).

- Reset: assert reset for 2 cycles with `in` toggling -> out=0, busy=0, pending=0 throughout and after; no blink follows.
- Single event: `in`=1 in cycle 0 only -> pending=1 in cycle 1; out=1 in cycles 2-9; out=0 in cycles 10-17 (OFF); IDLE with busy=0 from cycle 18.
- Burst of three: `in`=1 in cycles 0, 1, 2 -> out high in cycles 2-9, 19-26 and 36-43, and never otherwise; busy=0 from cycle 52.
- Saturation: `in` held high in cycles 0-9 -> pending goes 1,1,2,3,3...; exactly 4 blinks total; pending reaches 0 at the start of the last blink.
- Event during gap: single event at cycle 0, second event at cycle 12 (OFF phase) -> second blink at cycles 19-26.
- Reset mid-blink: 3 events queued; reset asserted in cycle 5 (in ON) -> out=0 and pending=0 from cycle 6; no further blinks.
